// File: rtl/fifo_async_write_ptr_pkg.sv
// Shared dual-clock FIFO helpers: depth derivation and the Gray full-compare
// target, used identically by the write- and read-pointer blocks.
package fifo_async_write_ptr_pkg;

  typedef struct packed {
    logic full;
    logic afull;
    logic ovf;
  } wflags_t;

  function automatic int fifo_depth(int ptr_w);
    return 1 << (ptr_w - 1);
  endfunction

  // Gray pointer of the read side as the write pointer will look when full:
  // top two bits inverted (both bits when ptr_w == 2).
  function automatic logic [31:0] full_target(logic [31:0] rg, int ptr_w);
    return rg ^ (32'd3 << (ptr_w - 2));
  endfunction

endpackage

// File: rtl/fifo_async_write_ptr_if.sv
// Write-side pointer bundle: request/clear in, read pointer in, RAM and flags out.
interface fifo_async_write_ptr_if #(parameter int PTR_WIDTH = 3);
  logic                 write_in;
  logic                 clear_ovf_in;
  logic [PTR_WIDTH-1:0] rptr_g_sync_in;
  logic [PTR_WIDTH-1:0] wptr_b_out;
  logic [PTR_WIDTH-1:0] wptr_g_out;
  logic [PTR_WIDTH-2:0] waddr_out;
  logic                 wen_out;
  logic                 full_out;
  logic                 almost_full_out;
  logic [PTR_WIDTH-1:0] level_out;
  logic                 overflow_out;

  modport master (
    output write_in, clear_ovf_in, rptr_g_sync_in,
    input  wptr_b_out, wptr_g_out, waddr_out, wen_out, full_out,
           almost_full_out, level_out, overflow_out
  );

  modport slave (
    input  write_in, clear_ovf_in, rptr_g_sync_in,
    output wptr_b_out, wptr_g_out, waddr_out, wen_out, full_out,
           almost_full_out, level_out, overflow_out
  );
endinterface

// File: rtl/fifo_async_write_ptr_gray2bin.sv
// Combinational Gray-to-binary converter (prefix XOR from the MSB down).
module fifo_async_write_ptr_gray2bin #(parameter int N = 3) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);
  always_comb begin
    bin = '0;
    bin[N-1] = gray[N-1];
    for (int i = N - 2; i >= 0; i--) bin[i] = bin[i+1] ^ gray[i];
  end
endmodule

// File: rtl/fifo_async_write_ptr.sv
// Write-domain pointer/flag logic for the dual-clock FIFO: binary+Gray write
// pointer, RAM write strobe, full/almost-full/level and sticky overflow.
module fifo_async_write_ptr
  import fifo_async_write_ptr_pkg::*;
#(
  parameter int PTR_WIDTH    = 3,
  parameter int AFULL_THRESH = 3
) (
  input logic                 write_clk,
  input logic                 rst_in,
  fifo_async_write_ptr_if.slave wp
);
  localparam int DEPTH = fifo_depth(PTR_WIDTH);
  localparam int AF_EFF = (AFULL_THRESH > DEPTH) ? DEPTH : AFULL_THRESH;
  localparam logic [PTR_WIDTH:0] AF_TH = (PTR_WIDTH+1)'(AF_EFF);

  logic [PTR_WIDTH-1:0] wb_q, wg_q, lvl_q;
  logic [PTR_WIDTH-1:0] wb_nx, wg_nx, lvl_nx, rb_sync, rg_full;
  logic                 accept, full_nx;
  wflags_t              flg_q;

  fifo_async_write_ptr_gray2bin #(.N(PTR_WIDTH)) u_g2b (
    .gray (wp.rptr_g_sync_in),
    .bin  (rb_sync)
  );

  // Accept against the registered full so a read release cannot let a write
  // slip in on the same edge the flag drops.
  assign accept  = wp.write_in & ~flg_q.full;
  assign wb_nx   = wb_q + PTR_WIDTH'(accept);
  assign wg_nx   = (wb_nx >> 1) ^ wb_nx;
  assign rg_full = PTR_WIDTH'(full_target(32'(wp.rptr_g_sync_in), PTR_WIDTH));
  assign full_nx = (wg_nx == rg_full);
  assign lvl_nx  = wb_nx - rb_sync;

  always_ff @(posedge write_clk) begin
    if (rst_in) begin
      wb_q  <= '0;
      wg_q  <= '0;
      lvl_q <= '0;
      flg_q <= '0;
    end else begin
      wb_q       <= wb_nx;
      wg_q       <= wg_nx;
      lvl_q      <= lvl_nx;
      flg_q.full <= full_nx;
      flg_q.afull <= ({1'b0, lvl_nx} >= AF_TH);
      if (wp.write_in & flg_q.full) flg_q.ovf <= 1'b1;
      else if (wp.clear_ovf_in)     flg_q.ovf <= 1'b0;
    end
  end

  assign wp.wptr_b_out      = wb_q;
  assign wp.wptr_g_out      = wg_q;
  assign wp.waddr_out       = wb_q[PTR_WIDTH-2:0];
  assign wp.wen_out         = accept;
  assign wp.full_out        = flg_q.full;
  assign wp.almost_full_out = flg_q.afull;
  assign wp.level_out       = lvl_q;
  assign wp.overflow_out    = flg_q.ovf;
endmodule

// File: tb/tb_fifo_async_write_ptr.sv
// Directed bench for the write-pointer block: stimulus pushes hand-computed
// expectations, a monitor pops and compares them around each write_clk edge.
module tb_fifo_async_write_ptr;
  localparam int PW = 3;

  typedef struct {
    logic          chk_wen;
    logic          wen;
    logic [PW-1:0] wb;
    logic [PW-1:0] wg;
    logic          full;
    logic          afull;
    logic [PW-1:0] lvl;
    logic          ovf;
  } exp_t;

  logic write_clk = 1'b0;
  logic rst_in;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  fifo_async_write_ptr_if #(.PTR_WIDTH(PW)) wif ();

  fifo_async_write_ptr #(.PTR_WIDTH(PW), .AFULL_THRESH(3)) dut (
    .write_clk (write_clk),
    .rst_in    (rst_in),
    .wp        (wif.slave)
  );

  always #5 write_clk = ~write_clk;

  function automatic logic [PW-1:0] gray(logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // One cycle: drive at negedge, record what must hold after the next posedge.
  task automatic vec(input logic rst, input logic wr, input logic clr, input logic [PW-1:0] rg,
                     input logic cw, input logic wen, input logic [PW-1:0] wb,
                     input logic [PW-1:0] wg, input logic full, input logic af,
                     input logic [PW-1:0] lvl, input logic ovf);
    exp_t e;
    @(negedge write_clk);
    rst_in = rst;
    wif.write_in = wr;
    wif.clear_ovf_in = clr;
    wif.rptr_g_sync_in = rg;
    e.chk_wen = cw; e.wen = wen; e.wb = wb; e.wg = wg;
    e.full = full; e.afull = af; e.lvl = lvl; e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Monitor: wen is combinational and checked just before the edge commits;
  // registered outputs are checked 1 time unit after it.
  initial begin
    exp_t e;
    logic wen_s;
    forever begin
      @(posedge write_clk);
      wen_s = wif.wen_out;
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_vec++;
        if ((e.chk_wen && wen_s !== e.wen) || wif.wptr_b_out !== e.wb ||
            wif.wptr_g_out !== e.wg || wif.waddr_out !== e.wb[PW-2:0] ||
            wif.full_out !== e.full || wif.almost_full_out !== e.afull ||
            wif.level_out !== e.lvl || wif.overflow_out !== e.ovf) begin
          n_err++;
          $display("FAIL vec%0d: got wen=%b wb=%b wg=%b wa=%b full=%b af=%b lvl=%0d ovf=%b, want wen=%b(chk %b) wb=%b wg=%b full=%b af=%b lvl=%0d ovf=%b",
                   n_vec, wen_s, wif.wptr_b_out, wif.wptr_g_out, wif.waddr_out,
                   wif.full_out, wif.almost_full_out, wif.level_out, wif.overflow_out,
                   e.wen, e.chk_wen, e.wb, e.wg, e.full, e.afull, e.lvl, e.ovf);
        end
      end
    end
  end

  initial begin
    logic [PW-1:0] wrap_wb [10] = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [PW-1:0] wrap_wg [10] = '{3'b101, 3'b100, 3'b000, 3'b001, 3'b011,
                                    3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    logic [PW-1:0] cur;
    int guard;
    rst_in = 1'b1;
    wif.write_in = 1'b0;
    wif.clear_ovf_in = 1'b0;
    wif.rptr_g_sync_in = '0;

    //   rst wr clr rg      cw wen wb    wg      full af lvl ovf
    vec(1, 1, 0, 3'b000,   0, 1, 3'd0, 3'b000, 0, 0, 3'd0, 0);
    vec(1, 1, 0, 3'b000,   1, 1, 3'd0, 3'b000, 0, 0, 3'd0, 0);
    // fill
    vec(0, 1, 0, 3'b000,   1, 1, 3'd1, 3'b001, 0, 0, 3'd1, 0);
    vec(0, 1, 0, 3'b000,   1, 1, 3'd2, 3'b011, 0, 0, 3'd2, 0);
    vec(0, 1, 0, 3'b000,   1, 1, 3'd3, 3'b010, 0, 1, 3'd3, 0);
    vec(0, 1, 0, 3'b000,   1, 1, 3'd4, 3'b110, 1, 1, 3'd4, 0);
    // overflow, hold, clear, clear+overflow
    vec(0, 1, 0, 3'b000,   1, 0, 3'd4, 3'b110, 1, 1, 3'd4, 1);
    vec(0, 0, 0, 3'b000,   1, 0, 3'd4, 3'b110, 1, 1, 3'd4, 1);
    vec(0, 0, 1, 3'b000,   1, 0, 3'd4, 3'b110, 1, 1, 3'd4, 0);
    vec(0, 1, 1, 3'b000,   1, 0, 3'd4, 3'b110, 1, 1, 3'd4, 1);
    // read release: same-cycle write rejected, next accepted
    vec(0, 1, 0, 3'b001,   1, 0, 3'd4, 3'b110, 0, 1, 3'd3, 1);
    vec(0, 1, 0, 3'b001,   1, 1, 3'd5, 3'b111, 1, 1, 3'd4, 1);
    vec(0, 0, 1, 3'b001,   1, 0, 3'd5, 3'b111, 1, 1, 3'd4, 0);
    // reader catches up to wptr-1, then wrap with level pinned at 1
    vec(0, 0, 0, 3'b110,   1, 0, 3'd5, 3'b111, 0, 0, 3'd1, 0);
    cur = 3'd5;
    for (int i = 0; i < 10; i++) begin
      vec(0, 1, 0, gray(cur), 1, 1, wrap_wb[i], wrap_wg[i], 0, 0, 3'd1, 0);
      cur = wrap_wb[i];
    end
    // build level 3 then reset mid-operation
    vec(0, 0, 0, 3'b110,   1, 0, 3'd7, 3'b100, 0, 1, 3'd3, 0);
    vec(1, 1, 0, 3'b110,   1, 1, 3'd0, 3'b000, 0, 0, 3'd0, 0);
    vec(0, 1, 0, 3'b000,   1, 1, 3'd1, 3'b001, 0, 0, 3'd1, 0);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge write_clk);
      guard++;
    end
    #2;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_async_write_ptr.md
Name: fifo_async_write_ptr

Overview:
Write-side pointer and flag logic for the dual-clock FIFO. It runs entirely in the write clock domain. It advances a binary/Gray write pointer on accepted writes and drives the RAM write address and enable. It compares against the synchronized read pointer (Gray, from the read-to-write syncer) to produce full, almost-full, fill level and a sticky overflow flag. It is the write-domain counterpart of the read-pointer block and must share its pointer encoding exactly.

Parameters:
PTR_WIDTH, 3, pointer width including wrap bit; FIFO depth = 2^(PTR_WIDTH-1)
AFULL_THRESH, 3, almost_full_out asserts when fill level >= this value (range 1..depth)

Ports:
write_clk  in  1  write-domain clock, all logic on posedge
rst_in  in  1  synchronous, active-high reset
write_in  in  1  write request this cycle
clear_ovf_in  in  1  clears sticky overflow flag
rptr_g_sync_in  in  PTR_WIDTH  read pointer (Gray), already synchronized into write_clk
wptr_b_out  out  PTR_WIDTH  registered binary write pointer
wptr_g_out  out  PTR_WIDTH  registered Gray write pointer, to write-to-read syncer
waddr_out  out  PTR_WIDTH-1  RAM write address = wptr_b_out[PTR_WIDTH-2:0]
wen_out  out  1  RAM write enable = write_in & ~full_out (combinational)
full_out  out  1  registered full flag
almost_full_out  out  1  registered almost-full flag
level_out  out  PTR_WIDTH  registered fill level, 0..depth
overflow_out  out  1  sticky: write attempted while full

Behaviour:
- Reset (rst_in=1 at posedge): wptr_b_out=0, wptr_g_out=0, full_out=0, almost_full_out=0 (level 0 < AFULL_THRESH), level_out=0, overflow_out=0. Reset has priority over every other input, including mid-burst writes; the next state is discarded.
- Accept: accept = write_in & ~full_out. wptr_b_next = wptr_b_out + accept, modulo 2^PTR_WIDTH, so it wraps naturally from all-ones to 0. wptr_g_next = (wptr_b_next>>1) ^ wptr_b_next. Both pointers register on the same edge; Gray only ever changes one bit per cycle.
- RAM write uses the current waddr_out and wen_out, so data is written on the same edge the pointer advances. Zero-cycle latency from write_in to RAM.
- rptr_b_sync = gray-to-binary(rptr_g_sync_in), combinational.
- Full: full_next = (wptr_g_next == {~rptr_g_sync_in[MSB:MSB-1], rptr_g_sync_in[MSB-2:0]}). For PTR_WIDTH=2, invert both bits. full_out <= full_next, so full is valid the edge after the write that fills the FIFO. There is no one-cycle write-past-full window.
- Level: level_next = wptr_b_next - rptr_b_sync (PTR_WIDTH-bit modulo subtract); level_out <= level_next. almost_full_out <= (level_next >= AFULL_THRESH).
- Flags are pessimistic. A stale read pointer can only hold full/level high longer, never under-report them. Deassertion follows a rptr_g_sync_in change by exactly one write_clk edge.
- Overflow: if write_in & full_out, then overflow_out <= 1 and the pointer holds. If clear_ovf_in and an overflowing write occur on the same edge, set wins and overflow_out stays 1. clear_ovf_in alone sets overflow_out <= 0.
- Simultaneous write and read-pointer advance while full: accept uses the registered full_out, so the write is rejected that cycle. Full drops next edge.

Decomposition:
- Shared fifo include: depth derivation localparam (DEPTH = 1<<(PTR_WIDTH-1)) and the full-compare helper, also used by the read side.
- Sub-module: reuse existing gray2bin (N=PTR_WIDTH) for rptr_g_sync_in.
- Binary-to-Gray stays inline, matching the read side.

Test Plan:
- Reset: rst_in=1 for 2 cycles with write_in=1 -> all outputs 0, wen_out=1, pointers do not advance while rst_in=1.
- Fill (PTR_WIDTH=3, rptr_g_sync_in=000): 4 consecutive writes -> wptr_b 1,2,3,4; wptr_g 001,011,010,110; almost_full_out=1 after 3rd write (level 3); full_out=1 and level_out=4 after 4th.
- Overflow: 5th write while full -> wen_out=0, wptr_b stays 4, overflow_out=1 next edge and holds. clear_ovf_in=1 with write_in=0 -> overflow_out=0. clear and overflowing write on same edge -> stays 1.
- Read release: while full, rptr_g_sync_in 000->001 -> next edge full_out=0, level_out=3. Write that same cycle is rejected; write next cycle accepted.
- Wrap: rptr tracks wptr-1 continuously, 10 writes -> wptr_b wraps 7->0 (Gray 100->000), full_out never asserts, level_out stays 1.
- Mid-operation reset: rst_in=1 at level 3 -> next edge level_out=0, pointers 0, flags cleared.
